// File: rtl/multicycle_mips_if.sv
// Memory-side bus of the multi-cycle MIPS core: instruction fetch port and
// single-port data SRAM port, both completed by a ready handshake.
interface multicycle_mips_if #(
  parameter int DMEM_AW = 7
);
  // instruction fetch port
  logic               imem_req;
  logic [31:0]        IR_addr;
  logic [31:0]        IR;
  logic               imem_ready;
  // data SRAM port (control strobes active low)
  logic               CEN;
  logic               WEN;
  logic               OEN;
  logic [DMEM_AW-1:0] A;
  logic [31:0]        ReadData2;
  logic [31:0]        ReadDataMem;
  logic               dmem_ready;

  modport master (
    output imem_req, IR_addr, CEN, WEN, OEN, A, ReadData2,
    input  IR, imem_ready, ReadDataMem, dmem_ready
  );

  modport slave (
    input  imem_req, IR_addr, CEN, WEN, OEN, A, ReadData2,
    output IR, imem_ready, ReadDataMem, dmem_ready
  );
endinterface

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core: FETCH / DECODE / EXEC / MEM / WB state machine with
// ready-handshaked instruction and data memories. Every memory-side output is
// forced to its idle value while rst is high.
module multicycle_mips #(
  parameter int          DMEM_AW  = 7,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_mips_if.master   bus,
  output logic [31:0]         RF_writedata,
  output logic                rf_we,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q;
  logic [31:0] a_q, b_q;
  logic [31:0] aluout_q;
  logic [31:0] mdr_q;
  logic [31:0] regs_q [32];

  // instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext_imm;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};

  logic is_rtype, r_legal, is_jr, is_addi, is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_jal, legal;

  assign is_rtype = (opcode == OP_RTYPE);
  assign r_legal  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_SLL) ||
                    (funct == FN_SRL) || (funct == FN_JR);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign legal    = (is_rtype && r_legal) || is_addi || is_lw || is_sw ||
                    is_beq || is_bne || is_j || is_jal;

  // $0 is hard-wired to zero on the read side as well as the write side
  logic [31:0] rf_rs, rf_rt;
  assign rf_rs = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rf_rt = (rt == 5'd0) ? 32'd0 : regs_q[rt];

  // PC was already advanced in FETCH, so the target is relative to PC+4
  logic [31:0] branch_target;
  logic        branch_taken;
  assign branch_target = pc_q + (sext_imm << 2);
  assign branch_taken  = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));

  // ALU: R-type uses B_reg, every I-type ALU use is an add with sext(imm)
  logic [31:0] alu_result;
  always_comb begin
    alu_result = 32'd0;
    if (is_rtype) begin
      case (funct)
        FN_ADD:  alu_result = a_q + b_q;
        FN_SUB:  alu_result = a_q - b_q;
        FN_AND:  alu_result = a_q & b_q;
        FN_OR:   alu_result = a_q | b_q;
        FN_SLT:  alu_result = {31'd0, $signed(a_q) < $signed(b_q)};
        FN_SLL:  alu_result = b_q << shamt;
        FN_SRL:  alu_result = b_q >> shamt;
        default: alu_result = 32'd0;
      endcase
    end else begin
      alu_result = a_q + sext_imm;
    end
  end

  // register-file write request, before the $0 filter
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  // next-state, PC update and all bus/observation outputs
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    bus.imem_req  = 1'b0;
    bus.CEN       = 1'b1;
    bus.WEN       = 1'b1;
    bus.OEN       = 1'b1;
    bus.A         = '0;
    bus.ReadData2 = 32'd0;
    wr_en         = 1'b0;
    wr_addr       = 5'd0;
    wr_data       = 32'd0;
    illegal       = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          if (bus.imem_ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!legal) begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end else if (is_j || is_jal) begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            wr_en   = is_jal;
            wr_addr = 5'd31;
            wr_data = pc_q;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_jr) begin
            pc_d    = a_q;
            state_d = S_FETCH;
          end else if (is_beq || is_bne) begin
            if (branch_taken) pc_d = branch_target;
            state_d = S_FETCH;
          end else if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          bus.CEN = 1'b0;
          bus.A   = aluout_q[DMEM_AW+1:2];
          if (is_sw) begin
            bus.WEN       = 1'b0;
            bus.ReadData2 = b_q;
          end else begin
            bus.OEN = 1'b0;
          end
          if (bus.dmem_ready) state_d = is_lw ? S_WB : S_FETCH;
        end
        S_WB: begin
          wr_en   = 1'b1;
          wr_addr = is_rtype ? rd : rt;
          wr_data = is_lw ? mdr_q : aluout_q;
        end
        default: state_d = S_FETCH;
      endcase
      if (state_q == S_WB) state_d = S_FETCH;
    end
  end

  assign bus.IR_addr   = pc_q;
  assign rf_we         = wr_en && (wr_addr != 5'd0);
  assign RF_writedata  = rf_we ? wr_data : 32'd0;

  // state, PC and datapath latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      aluout_q <= 32'd0;
      mdr_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      case (state_q)
        S_FETCH:  if (bus.imem_ready) ir_q <= bus.IR;
        S_DECODE: begin
          a_q <= rf_rs;
          b_q <= rf_rt;
        end
        S_EXEC:   aluout_q <= alu_result;
        S_MEM:    if (bus.dmem_ready && is_lw) mdr_q <= bus.ReadDataMem;
        default:  ;
      endcase
    end
  end

  // register file; cleared on reset, $0 never written because rf_we filters it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (rf_we) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_multicycle_mips.sv
// Scoreboard bench for multicycle_mips: stimulus pushes expected fetch
// addresses, RF writes and data-memory accesses; a negedge monitor pops and
// compares them as the core produces them.
module tb_multicycle_mips;

  localparam int DMEM_AW = 7;

  logic        clk;
  logic        rst;
  logic [31:0] RF_writedata;
  logic        rf_we;
  logic        illegal;

  multicycle_mips_if #(.DMEM_AW(DMEM_AW)) bus ();

  multicycle_mips #(.DMEM_AW(DMEM_AW), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .RF_writedata (RF_writedata),
    .rf_we        (rf_we),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory models ----------------
  logic [31:0] imem [64];
  logic [31:0] dmem [128];
  int          dmem_wait;
  int          dwait_cnt;
  logic        dmem_clear;

  assign bus.imem_ready  = 1'b1;
  assign bus.IR          = imem[bus.IR_addr[7:2]];
  assign bus.dmem_ready  = !bus.CEN && (dwait_cnt >= dmem_wait);
  assign bus.ReadDataMem = dmem[bus.A];

  always @(posedge clk) begin
    if (!bus.CEN && !bus.dmem_ready) dwait_cnt <= dwait_cnt + 1;
    else                             dwait_cnt <= 0;
    if (dmem_clear) begin
      for (int i = 0; i < 128; i++) dmem[i] <= 32'd0;
    end else if (!bus.CEN && !bus.WEN && bus.dmem_ready) begin
      dmem[bus.A] <= bus.ReadData2;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    int          gap;   // required cycles since previous write, 0 = unchecked
  } wr_t;

  typedef struct {
    logic [31:0] a;
    logic        wen;
    logic        oen;
    logic [31:0] wdata;
    int          len;   // required CEN-low cycles, -1 = unchecked
  } mem_t;

  logic [31:0] exp_fetch [$];
  wr_t         exp_wr    [$];
  mem_t        exp_mem   [$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int last_wr = -1;
  int ill_count = 0;
  logic ill_prev = 1'b0;
  logic in_acc = 1'b0;
  logic have_cur = 1'b0;
  int   acc_len = 0;
  mem_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic wr_t mk_wr(input logic [31:0] d, input int g);
    wr_t w;
    w.data = d;
    w.gap  = g;
    return w;
  endfunction

  function automatic mem_t mk_mem(input logic [31:0] a, input logic wen, input logic oen,
                                  input logic [31:0] wd, input int len);
    mem_t m;
    m.a = a; m.wen = wen; m.oen = oen; m.wdata = wd; m.len = len;
    return m;
  endfunction

  // monitor: one pass per negedge, compares whatever the core presents
  initial begin
    logic [31:0] fa;
    wr_t w;
    forever begin
      @(negedge clk);
      cycle++;
      if (bus.imem_req && bus.imem_ready && exp_fetch.size() > 0) begin
        fa = exp_fetch.pop_front();
        check("fetch_addr", bus.IR_addr, fa);
        $display("fetch  addr=%h", bus.IR_addr);
      end
      if (rf_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rf_write: got %h expected no write", RF_writedata);
        end else begin
          w = exp_wr.pop_front();
          check("rf_writedata", RF_writedata, w.data);
          if (w.gap > 0 && last_wr >= 0) check("rf_write_spacing", cycle - last_wr, w.gap);
          $display("rfwr   data=%h cycle=%0d", RF_writedata, cycle);
        end
        last_wr = cycle;
      end else if (RF_writedata !== 32'd0) begin
        check("rf_writedata_idle", RF_writedata, 32'd0);
      end
      if (illegal) begin
        ill_count++;
        check("illegal_pulse_width", {31'd0, ill_prev}, 32'd0);
        $display("illegal at pc=%h", bus.IR_addr);
      end
      ill_prev = illegal;
      if (!bus.CEN) begin
        if (!in_acc) begin
          in_acc  = 1'b1;
          acc_len = 0;
          if (exp_mem.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dmem_access: got A=%h expected no access", bus.A);
          end else begin
            cur      = exp_mem.pop_front();
            have_cur = 1'b1;
          end
        end
        acc_len++;
        if (have_cur) begin
          check("dmem_A", {{(32-DMEM_AW){1'b0}}, bus.A}, cur.a);
          check("dmem_WEN", {31'd0, bus.WEN}, {31'd0, cur.wen});
          check("dmem_OEN", {31'd0, bus.OEN}, {31'd0, cur.oen});
          if (!cur.wen) check("dmem_wdata", bus.ReadData2, cur.wdata);
        end
      end else if (in_acc) begin
        in_acc = 1'b0;
        if (have_cur && cur.len > 0) check("cen_low_cycles", acc_len, cur.len);
        $display("dmem   A=%h cen_low=%0d", cur.a, acc_len);
        have_cur = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_start;
    @(posedge clk); #1;
    rst        = 1'b1;
    dmem_clear = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    @(posedge clk); #1;
    dmem_clear = 1'b0;
    @(posedge clk); #1;
    last_wr   = -1;
    ill_count = 0;
  endtask

  task automatic release_rst;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_fetch.size() != 0 || exp_wr.size() != 0 || exp_mem.size() != 0 || in_acc)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending items expected 0",
               exp_fetch.size() + exp_wr.size() + exp_mem.size());
    end
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    dmem_wait  = 0;
    dmem_clear = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;

    // ---- reset + arithmetic + memory-with-waits program ----
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    imem[3] = enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A);
    imem[4] = enc_r(5'd0, 5'd1, 5'd5, 5'd4, 6'h00);
    imem[5] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    imem[6] = enc_i(6'h23, 5'd0, 5'd6, 16'd8);
    dmem_wait = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_clear = 1'b0;
      check("reset_IR_addr", bus.IR_addr, 32'h0);
      check("reset_imem_req", {31'd0, bus.imem_req}, 32'd0);
      check("reset_CEN", {31'd0, bus.CEN}, 32'd1);
    end
    for (int i = 0; i < 7; i++) exp_fetch.push_back(32'(i * 4));
    exp_wr.push_back(mk_wr(32'd5, 0));
    exp_wr.push_back(mk_wr(32'hFFFFFFFD, 4));
    exp_wr.push_back(mk_wr(32'd2, 4));
    exp_wr.push_back(mk_wr(32'd1, 4));
    exp_wr.push_back(mk_wr(32'd80, 4));
    exp_wr.push_back(mk_wr(32'd5, 15));
    exp_mem.push_back(mk_mem(32'd2, 1'b0, 1'b1, 32'd5, 4));
    exp_mem.push_back(mk_mem(32'd2, 1'b1, 1'b0, 32'd0, 4));
    release_rst();
    @(negedge clk);
    check("first_fetch_req", {31'd0, bus.imem_req}, 32'd1);
    drain(200);
    repeat (3) @(negedge clk);
    check("store_landed", dmem[2], 32'd5);

    // ---- control flow, illegal and $0 program ----
    load_start();
    dmem_wait = 0;
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
    imem[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    imem[5]  = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
    imem[6]  = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
    imem[7]  = enc_i(6'h05, 5'd0, 5'd0, 16'd4);
    imem[8]  = enc_j(6'h03, 26'h10);
    imem[9]  = enc_i(6'h08, 5'd0, 5'd8, 16'd9);
    imem[10] = 32'hFC000000;
    imem[11] = enc_r(5'd1, 5'd1, 5'd0, 5'd0, 6'h20);
    imem[12] = enc_i(6'h08, 5'd0, 5'd10, 16'd3);
    imem[13] = enc_j(6'h02, 26'hD);
    imem[16] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    exp_fetch.push_back(32'h00);
    exp_fetch.push_back(32'h04);
    exp_fetch.push_back(32'h08);
    exp_fetch.push_back(32'h0C);
    exp_fetch.push_back(32'h10);
    exp_fetch.push_back(32'h1C);
    exp_fetch.push_back(32'h20);
    exp_fetch.push_back(32'h40);
    exp_fetch.push_back(32'h24);
    exp_fetch.push_back(32'h28);
    exp_fetch.push_back(32'h2C);
    exp_fetch.push_back(32'h30);
    exp_fetch.push_back(32'h34);
    exp_wr.push_back(mk_wr(32'd7, 0));
    exp_wr.push_back(mk_wr(32'h24, 0));
    exp_wr.push_back(mk_wr(32'd9, 0));
    exp_wr.push_back(mk_wr(32'd3, 0));
    release_rst();
    drain(200);
    repeat (10) @(negedge clk);
    check("illegal_count", ill_count, 32'd1);

    // ---- reset in the middle of a stalled store ----
    load_start();
    dmem_wait = 1000;
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    exp_fetch.push_back(32'h00);
    exp_fetch.push_back(32'h04);
    exp_wr.push_back(mk_wr(32'd5, 0));
    exp_mem.push_back(mk_mem(32'd2, 1'b0, 1'b1, 32'd5, -1));
    release_rst();
    n = 0;
    while (!in_acc && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_acc) begin
      errors++;
      $display("FAIL mid_wait_for_mem: got no MEM access expected one within 40 cycles");
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_CEN", {31'd0, bus.CEN}, 32'd1);
    check("mid_rst_pc", bus.IR_addr, 32'h0);
    check("mid_rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("mid_rst_no_store", dmem[2], 32'd0);
    check("mid_rst_pending_wr", exp_wr.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
